// File: rtl/reg_select_pipe.sv
// rtl/reg_select_pipe.sv - register select decode with writeback-delayed destination select
// Decode stage produces one-hot A/B/D selects; D then rides WB_STAGES registers to writeback.
module reg_select_pipe #(
  parameter int NREGS     = 32,
  parameter int WB_STAGES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ibus,
  input  logic             in_valid,
  input  logic             b_from_rd,
  input  logic             no_write,
  input  logic             stall,
  input  logic             flush,
  output logic [NREGS-1:0] Aselect,
  output logic [NREGS-1:0] Bselect,
  output logic             sel_valid,
  output logic [NREGS-1:0] Dselect_wb,
  output logic             wb_valid
);

  localparam logic [4:0] XZR = 5'd31;

  // Field values at or above NREGS name no physical register and decode to zero.
  function automatic logic [NREGS-1:0] decode(input logic [4:0] k);
    logic [NREGS-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (k == i[4:0]) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic [4:0]       rd_fld, rn_fld, b_fld;
  logic             cap_valid;
  logic [NREGS-1:0] a_nxt, b_nxt, d_nxt;
  logic [NREGS-1:0] d_q;
  logic             dv_q;
  logic [NREGS-1:0] d_pipe  [WB_STAGES];
  logic             wv_pipe [WB_STAGES];
  logic             unused_ibus_bits;

  assign unused_ibus_bits = ^{ibus[31:21], ibus[15:10]};

  always_comb begin
    rd_fld    = ibus[4:0];
    rn_fld    = ibus[9:5];
    b_fld     = b_from_rd ? ibus[4:0] : ibus[20:16];
    cap_valid = in_valid & ~flush;
    a_nxt     = '0;
    b_nxt     = '0;
    d_nxt     = '0;
    if (cap_valid) begin
      a_nxt = decode(rn_fld);
      b_nxt = decode(b_fld);
      if (!no_write && rd_fld != XZR) d_nxt = decode(rd_fld);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Aselect   <= '0;
      Bselect   <= '0;
      sel_valid <= 1'b0;
      d_q       <= '0;
      dv_q      <= 1'b0;
      for (int i = 0; i < WB_STAGES; i++) begin
        d_pipe[i]  <= '0;
        wv_pipe[i] <= 1'b0;
      end
    end else if (!stall) begin
      Aselect    <= a_nxt;
      Bselect    <= b_nxt;
      sel_valid  <= cap_valid;
      d_q        <= d_nxt;
      dv_q       <= cap_valid;
      d_pipe[0]  <= d_q;
      wv_pipe[0] <= dv_q;
      for (int i = 1; i < WB_STAGES; i++) begin
        d_pipe[i]  <= d_pipe[i-1];
        wv_pipe[i] <= wv_pipe[i-1];
      end
    end
  end

  assign Dselect_wb = d_pipe[WB_STAGES-1];
  assign wb_valid   = wv_pipe[WB_STAGES-1];

endmodule

// File: tb/tb_reg_select_pipe.sv
// tb/tb_reg_select_pipe.sv - directed self-checking bench for reg_select_pipe
module tb_reg_select_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, b_from_rd, no_write, stall, flush;
  logic [31:0] ibus;
  logic [31:0] a32, b32, d32;
  logic        sv32, wv32;
  logic [15:0] a16, b16, d16;
  logic        sv16, wv16;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  reg_select_pipe #(.NREGS(32), .WB_STAGES(3)) dut32 (
    .clk(clk), .reset(reset), .ibus(ibus), .in_valid(in_valid), .b_from_rd(b_from_rd),
    .no_write(no_write), .stall(stall), .flush(flush), .Aselect(a32), .Bselect(b32),
    .sel_valid(sv32), .Dselect_wb(d32), .wb_valid(wv32));

  reg_select_pipe #(.NREGS(16), .WB_STAGES(3)) dut16 (
    .clk(clk), .reset(reset), .ibus(ibus), .in_valid(in_valid), .b_from_rd(b_from_rd),
    .no_write(no_write), .stall(stall), .flush(flush), .Aselect(a16), .Bselect(b16),
    .sel_valid(sv16), .Dselect_wb(d16), .wb_valid(wv16));

  function automatic logic [31:0] mk(input int rd, input int rn, input int rm);
    logic [4:0] d, n, m;
    d = rd[4:0]; n = rn[4:0]; m = rm[4:0];
    return {11'b0, m, 6'b0, n, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    b_from_rd = 1'b0; no_write = 1'b0; ibus = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; stall = 1'b1; flush = 1'b0;
    b_from_rd = 1'b0; no_write = 1'b0; ibus = mk(3, 5, 7);
    step();
    reset = 1'b0; in_valid = 1'b0; stall = 1'b0;
    n_cmp++; if (a32 !== 32'h0) begin n_err++; $display("FAIL reset_a got %h want 0", a32); end
    n_cmp++; if (b32 !== 32'h0) begin n_err++; $display("FAIL reset_b got %h want 0", b32); end
    n_cmp++; if (sv32 !== 1'b0) begin n_err++; $display("FAIL reset_sv got %b want 0", sv32); end
    n_cmp++; if (d32 !== 32'h0) begin n_err++; $display("FAIL reset_d got %h want 0", d32); end
    n_cmp++; if (wv32 !== 1'b0) begin n_err++; $display("FAIL reset_wv got %b want 0", wv32); end
    n_cmp++; if (wv16 !== 1'b0) begin n_err++; $display("FAIL reset_wv16 got %b want 0", wv16); end
  endtask

  task automatic test_basic();
    do_reset();
    ibus = mk(3, 5, 7); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (a32 !== 32'h20) begin n_err++; $display("FAIL basic_a got %h want 20", a32); end
    n_cmp++; if (b32 !== 32'h80) begin n_err++; $display("FAIL basic_b got %h want 80", b32); end
    n_cmp++; if (sv32 !== 1'b1) begin n_err++; $display("FAIL basic_sv got %b want 1", sv32); end
    step();
    n_cmp++; if (sv32 !== 1'b0 || a32 !== 32'h0) begin n_err++; $display("FAIL basic_idle got sv=%b a=%h want 0/0", sv32, a32); end
    step();
    n_cmp++; if (wv32 !== 1'b0) begin n_err++; $display("FAIL basic_early_wv got %b want 0", wv32); end
    step();
    n_cmp++; if (d32 !== 32'h8) begin n_err++; $display("FAIL basic_d got %h want 8", d32); end
    n_cmp++; if (wv32 !== 1'b1) begin n_err++; $display("FAIL basic_wv got %b want 1", wv32); end
  endtask

  task automatic test_store_xzr();
    do_reset();
    ibus = mk(31, 2, 7); b_from_rd = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; b_from_rd = 1'b0;
    n_cmp++; if (a32 !== 32'h4) begin n_err++; $display("FAIL store_a got %h want 4", a32); end
    n_cmp++; if (b32 !== 32'h8000_0000) begin n_err++; $display("FAIL store_b got %h want 80000000", b32); end
    step(); step(); step();
    n_cmp++; if (d32 !== 32'h0) begin n_err++; $display("FAIL store_d got %h want 0", d32); end
    n_cmp++; if (wv32 !== 1'b1) begin n_err++; $display("FAIL store_wv got %b want 1", wv32); end
  endtask

  task automatic test_no_write();
    do_reset();
    ibus = mk(6, 1, 1); no_write = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; no_write = 1'b0;
    n_cmp++; if (a32 !== 32'h2) begin n_err++; $display("FAIL nowr_a got %h want 2", a32); end
    step(); step(); step();
    n_cmp++; if (d32 !== 32'h0 || wv32 !== 1'b1) begin n_err++; $display("FAIL nowr_d got %h/%b want 0/1", d32, wv32); end
  endtask

  task automatic test_narrow();
    do_reset();
    ibus = mk(4, 20, 15); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (a16 !== 16'h0) begin n_err++; $display("FAIL narrow_a got %h want 0", a16); end
    n_cmp++; if (b16 !== 16'h8000) begin n_err++; $display("FAIL narrow_b got %h want 8000", b16); end
    n_cmp++; if (sv16 !== 1'b1) begin n_err++; $display("FAIL narrow_sv got %b want 1", sv16); end
    step(); step(); step();
    n_cmp++; if (d16 !== 16'h10 || wv16 !== 1'b1) begin n_err++; $display("FAIL narrow_d got %h/%b want 0010/1", d16, wv16); end
  endtask

  task automatic test_stall();
    int          rds [14] = '{1, 2, 9, 9, 9, 3, 4, 0, 0, 0, 0, 0, 0, 0};
    bit          sts [14] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] exp_d [4] = '{32'h2, 32'h4, 32'h8, 32'h10};
    logic [31:0] got [$];
    do_reset();
    for (int i = 0; i < 14; i++) begin
      ibus = mk(rds[i], rds[i], rds[i]);
      in_valid = (rds[i] != 0);
      stall = sts[i];
      step();
      if (!sts[i] && wv32) got.push_back(d32);
      if (i == 4) begin
        n_cmp++; if (a32 !== 32'h4) begin n_err++; $display("FAIL stall_hold_a got %h want 4", a32); end
      end
    end
    stall = 1'b0; in_valid = 1'b0;
    n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL stall_count got %0d want 4", got.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) begin
        n_cmp++; if (got[k] !== exp_d[k]) begin n_err++; $display("FAIL stall_seq%0d got %h want %h", k, got[k], exp_d[k]); end
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp_a  [6] = '{32'h2, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0};
    logic        exp_sv [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp_d  [6] = '{32'h0, 32'h0, 32'h0, 32'h2, 32'h0, 32'h8};
    logic        exp_wv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ibus = mk(i + 1, i + 1, i + 1);
      in_valid = (i < 3);
      flush = (i == 1);
      step();
      n_cmp++; if (a32 !== exp_a[i] || b32 !== exp_a[i]) begin n_err++; $display("FAIL flush_sel%0d got a=%h b=%h want %h", i, a32, b32, exp_a[i]); end
      n_cmp++; if (sv32 !== exp_sv[i]) begin n_err++; $display("FAIL flush_sv%0d got %b want %b", i, sv32, exp_sv[i]); end
      n_cmp++; if (d32 !== exp_d[i] || wv32 !== exp_wv[i]) begin n_err++; $display("FAIL flush_wb%0d got %h/%b want %h/%b", i, d32, wv32, exp_d[i], exp_wv[i]); end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      ibus = mk(i, i, i); in_valid = 1'b1;
      step();
    end
    reset = 1'b1; stall = 1'b1; flush = 1'b1; ibus = mk(7, 7, 7);
    step();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (a32 !== 32'h0 || b32 !== 32'h0 || sv32 !== 1'b0) begin n_err++; $display("FAIL rmid_sel got %h/%h/%b want 0", a32, b32, sv32); end
    n_cmp++; if (d32 !== 32'h0 || wv32 !== 1'b0) begin n_err++; $display("FAIL rmid_wb got %h/%b want 0/0", d32, wv32); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (d32 !== 32'h0 || wv32 !== 1'b0) begin n_err++; $display("FAIL rmid_stale%0d got %h/%b want 0/0", i, d32, wv32); end
    end
    ibus = mk(5, 1, 1); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    n_cmp++; if (wv32 !== 1'b0) begin n_err++; $display("FAIL rmid_early got %b want 0", wv32); end
    step();
    n_cmp++; if (d32 !== 32'h20 || wv32 !== 1'b1) begin n_err++; $display("FAIL rmid_after got %h/%b want 20/1", d32, wv32); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_store_xzr();
    test_no_write();
    test_narrow();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_select_pipe.md
REG_SELECT_PIPE -- requirements
Module: reg_select_pipe

Interface
REQ-001 The block SHALL have parameter NREGS, default 32, meaning the number of architectural registers, legal range 2..32.
REQ-002 The block SHALL have parameter WB_STAGES, default 3, meaning the number of register stages between the decode stage and the Dselect_wb output, legal range 1..8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ibus, input, 32 bits: the instruction word; Rd=ibus[4:0], Rn=ibus[9:5], Rm=ibus[20:16].
REQ-006 The block SHALL have port in_valid, input, 1 bit: ibus holds a valid instruction this cycle.
REQ-007 The block SHALL have port b_from_rd, input, 1 bit: when 1 (store format), B decodes from ibus[4:0] instead of ibus[20:16].
REQ-008 The block SHALL have port no_write, input, 1 bit: when 1, the instruction writes no register.
REQ-009 The block SHALL have port stall, input, 1 bit: hold all pipeline state.
REQ-010 The block SHALL have port flush, input, 1 bit: kill the instruction entering the decode stage.
REQ-011 The block SHALL have port Aselect, output, NREGS bits: registered one-hot read-port-A select.
REQ-012 The block SHALL have port Bselect, output, NREGS bits: registered one-hot read-port-B select.
REQ-013 The block SHALL have port sel_valid, output, 1 bit: Aselect and Bselect are valid.
REQ-014 The block SHALL have port Dselect_wb, output, NREGS bits: one-hot write select delayed to writeback.
REQ-015 The block SHALL have port wb_valid, output, 1 bit: Dselect_wb is valid.

Function
REQ-016 Decode SHALL map field value k (0..31) to a vector with only bit k set when k < NREGS, and to all-zero when k >= NREGS.
REQ-017 Register 31 (XZR) SHALL decode normally on A and B, and SHALL force the D select to all-zero.
REQ-018 The D select SHALL be all-zero when no_write=1.
REQ-019 In a non-stall cycle, the decode stage SHALL capture decode(Rn), decode(B field), decode(Rd) and valid = in_valid & ~flush.
REQ-020 A captured invalid entry SHALL carry all-zero A, B and D selects, so every select output is zero whenever its valid is 0.
REQ-021 Aselect, Bselect and sel_valid SHALL appear one clock after capture, giving a latency of 1.
REQ-022 The D select and its valid SHALL then shift through WB_STAGES registers, so Dselect_wb and wb_valid appear 1+WB_STAGES clocks after capture when there are no stalls.
REQ-023 While stall=1, every stage SHALL hold its value, ibus SHALL be ignored, and no entry SHALL be lost or duplicated.
REQ-024 When stall=1 and flush=1 together, stall SHALL win and flush SHALL be ignored that cycle.
REQ-025 Flush SHALL affect only the entry being captured; entries already in the pipeline SHALL complete.
REQ-026 Every output SHALL be a register output, with no combinational path from inputs to outputs.
REQ-027 Each output select vector SHALL contain at most one set bit in every cycle.

Reset
REQ-028 While reset=1 at a rising edge, all stages SHALL clear, forcing Aselect, Bselect and Dselect_wb to 0 and sel_valid and wb_valid to 0 on the next cycle.
REQ-029 Reset SHALL take priority over stall and flush.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight entries; the first instruction captured after reset deasserts SHALL produce outputs with normal latency.

Verification
REQ-031 Basic latency: NREGS=32, WB_STAGES=3, ibus with Rd=3, Rn=5, Rm=7, in_valid=1 -> next cycle Aselect=0x20, Bselect=0x80, sel_valid=1; 4 cycles after capture Dselect_wb=0x8, wb_valid=1.
REQ-032 Store and zero-register: b_from_rd=1 with Rd=31, Rn=2 -> Bselect=0x8000_0000, Aselect=0x4, Dselect_wb=0 with wb_valid=1.
REQ-033 Narrow register file: NREGS=16 with Rn=20, Rm=15 -> Aselect=0, Bselect=0x8000.
REQ-034 Stall hold: stall=1 for 3 cycles mid-stream of back-to-back instructions Rd=1,2,3,4 -> Dselect_wb sequence is 0x2, 0x4, 0x8, 0x10 with no gaps or repeats beyond the stall-hold cycles.
REQ-035 Flush: flush=1 on the Rd=2 instruction -> that slot gives sel_valid=0 and wb_valid=0 with all-zero selects; the neighbouring instructions are unaffected.
REQ-036 Reset mid-stream: reset=1 for 1 cycle with 3 entries in flight -> all outputs are 0 the next cycle and no stale Dselect_wb appears afterwards.
